sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages, i.e. the `data_sram_*` handshake consumed by the MEM stage). It grants address phases with data priority and a hold-until-accepted lock. It tracks outstanding transactions in an in-order ID FIFO so each `mem_data_ok`/`mem_rdata` beat is returned to the requester that issued it. It sits between the pipeline and the AXI bridge.

## Interface
- `DEPTH`, default 4: maximum outstanding accepted-but-unanswered transactions; power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `inst_req` in 1: instruction request.
- `inst_wr` in 1: instruction write flag.
- `inst_size` in 2: instruction access size.
- `inst_wstrb` in 4: instruction write strobes.
- `inst_addr` in 32: instruction address.
- `inst_wdata` in 32: instruction write data.
- `inst_addr_ok` out 1: instruction address phase accepted.
- `inst_data_ok` out 1: instruction data phase complete.
- `inst_rdata` out 32: instruction read data.
- `data_req` in 1: data request.
- `data_wr` in 1: data write flag.
- `data_size` in 2: data access size.
- `data_wstrb` in 4: data write strobes.
- `data_addr` in 32: data address.
- `data_wdata` in 32: data write data.
- `data_addr_ok` out 1: data address phase accepted.
- `data_data_ok` out 1: data data phase complete.
- `data_rdata` out 32: data read data.
- `mem_req` out 1: shared-port request.
- `mem_wr` out 1: shared-port write flag.
- `mem_size` out 2: shared-port access size.
- `mem_wstrb` out 4: shared-port write strobes.
- `mem_addr` out 32: shared-port address.
- `mem_wdata` out 32: shared-port write data.
- `mem_addr_ok` in 1: shared-port address phase accepted.
- `mem_data_ok` in 1: shared-port data phase complete.
- `mem_rdata` in 32: shared-port read data.

## Operation
- Grant state machine:
  - States: `IDLE`, `LOCK_I`, `LOCK_D`.
  - In `IDLE`, the owner is data if `data_req`, else inst if `inst_req`, else none.
  - In `LOCK_x`, the owner is fixed to x.
- Issue condition: `mem_req` = owner's req && !full. `mem_wr/size/wstrb/addr/wdata` are muxed from the owner. With no owner, the mux selects inst fields and `mem_req`=0.
- Transitions:
  - Acceptance (`mem_req && mem_addr_ok`) → `IDLE`.
  - `mem_req` asserted but not accepted → `LOCK_<owner>`, held until acceptance.
  - Owner's req dropping while locked (protocol violation) → return to `IDLE`.
- `inst_addr_ok` = `mem_addr_ok && mem_req && owner==inst`; `data_addr_ok` likewise for data. The non-owner never sees `addr_ok`.
- ID FIFO:
  - `DEPTH` entries of 1 bit (0=inst, 1=data), with `log2(DEPTH)`-bit wrapping rd/wr pointers and a `log2(DEPTH)+1`-bit count.
  - Push the owner ID on acceptance; pop on `mem_data_ok` when count>0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - full = count==DEPTH, which blocks issue (`mem_req`=0) even if a pop occurs the same cycle. empty = count==0.
- Return routing: `inst_data_ok` = `mem_data_ok && !empty && head==0`; `data_data_ok` = `mem_data_ok && !empty && head==1`. A `mem_data_ok` while empty is dropped and no state changes.
- `inst_rdata` and `data_rdata` both equal `mem_rdata` (combinational broadcast). Requesters qualify with their own `data_ok`.
- Writes occupy a FIFO slot and receive `data_ok` like reads.
- Reset (any time, including mid-lock or with entries outstanding): state `IDLE`, pointers and count 0. Transactions in flight at reset are forgotten.

## Timing
- Request path is zero-latency combinational: req → `mem_req`/fields; `mem_addr_ok` → `*_addr_ok`; `mem_data_ok` → `*_data_ok`.
- State, pointers and count update one edge after the event.
- Output values under reset: `mem_req`=0, all `*_addr_ok`=0, all `*_data_ok`=0 (given `mem_*_ok` low).
- Back-to-back acceptance every cycle is sustained until full. Throughput is one address phase per cycle.
- Response order equals acceptance order; no reordering between requesters.

## Test plan
- Both `inst_req` and `data_req` high in `IDLE`, `mem_addr_ok`=1: data accepted first (`data_addr_ok`=1, `mem_addr`=`data_addr`). Inst is accepted next cycle. Two `mem_data_ok` beats with rdata 0xAAAA0000 then 0x1234 → `data_data_ok` first, then `inst_data_ok`.
- `inst_req` high with `mem_addr_ok`=0 for 3 cycles, `data_req` rises at cycle 1: `mem_addr` stays `inst_addr` (`LOCK_I`). When `addr_ok` rises, `inst_addr_ok`=1; the data request is issued the following cycle.
- DEPTH=4: issue 4 inst reads with no `data_ok` → 5th cycle `mem_req`=0. One `mem_data_ok` → `inst_data_ok`=1, count 3, `mem_req` reasserts next cycle.
- Simultaneous accept and `data_ok` with count=2: count stays 2. Pointers wrap correctly over 10 mixed transactions with ID sequence preserved.
- `mem_data_ok`=1 with FIFO empty: both `*_data_ok`=0, count stays 0.
- Assert `reset` asynchronously mid-`LOCK_D` with 3 outstanding: `mem_req`=0 immediately. After release, count=0 and arbitration restarts in `IDLE`.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// One sram-like handshake: request fields flow master->slave, ok strobes and read data flow back.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one sram port between inst and data requesters; data wins in IDLE, grant held until accepted.
// Zero-latency combinational request/response paths; issue stalls while DEPTH transactions are outstanding.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t          state, state_next;
  logic            own_i, own_d, owner_req, issue;
  logic            full, empty, push, pop, head;
  logic [DEPTH-1:0] ids;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    own_i      = 1'b0;
    own_d      = 1'b0;
    state_next = state;
    case (state)
      LOCK_I:  own_i = 1'b1;
      LOCK_D:  own_d = 1'b1;
      default: begin
        own_d = data.req;
        own_i = !data.req && inst.req;
      end
    endcase
    owner_req = (own_d && data.req) || (own_i && inst.req);
    // Reset gates issue so nothing escapes while the state is being cleared.
    issue = owner_req && !full && !reset;
    if (issue && mem.addr_ok) state_next = IDLE;
    else if (issue)           state_next = own_d ? LOCK_D : LOCK_I;
    else if (!owner_req)      state_next = IDLE;
  end

  assign mem.req   = issue;
  assign mem.wr    = own_d ? data.wr    : inst.wr;
  assign mem.size  = own_d ? data.size  : inst.size;
  assign mem.wstrb = own_d ? data.wstrb : inst.wstrb;
  assign mem.addr  = own_d ? data.addr  : inst.addr;
  assign mem.wdata = own_d ? data.wdata : inst.wdata;

  assign inst.addr_ok = mem.addr_ok && issue && own_i;
  assign data.addr_ok = mem.addr_ok && issue && own_d;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = issue && mem.addr_ok;
  assign pop   = mem.data_ok && !empty;
  assign head  = ids[rd_ptr];

  // Responses come back in acceptance order; the head ID says whose beat this is.
  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop && head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ids    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= own_d;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboarded bench for sram_req_arbiter: expected owner IDs queued at acceptance, checked at each data_ok beat.
module tb_sram_req_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_req_arbiter_if ii();
  sram_req_arbiter_if di();
  sram_req_arbiter_if mi();

  sram_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .inst(ii), .data(di), .mem(mi)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_inst(input logic r, input logic w, input logic [31:0] a);
    ii.req = r; ii.wr = w; ii.addr = a; ii.wdata = ~a;
    ii.size = 2'd2; ii.wstrb = w ? 4'hf : 4'h0;
  endtask

  task automatic set_data(input logic r, input logic w, input logic [31:0] a);
    di.req = r; di.wr = w; di.addr = a; di.wdata = a ^ 32'h5a5a5a5a;
    di.size = 2'd1; di.wstrb = w ? 4'h3 : 4'h0;
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    mi.data_ok = v; mi.rdata = d;
  endtask

  task automatic idle_inputs();
    set_inst(1'b0, 1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0);
    mi.addr_ok = 1'b0;
    beat(1'b0, 32'h0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (mi.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mi.req); end
    checks++; if (ii.addr_ok !== 1'b0 || di.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got=%b%b exp=00", ii.addr_ok, di.addr_ok); end
    checks++; if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%b%b exp=00", ii.data_ok, di.data_ok); end
    set_inst(1'b1, 1'b0, 32'h10); set_data(1'b1, 1'b0, 32'h20); mi.addr_ok = 1'b1;
    #1;
    checks++; if (mi.req !== 1'b0) begin errors++; $display("FAIL reset_req_gated got=%b exp=0", mi.req); end
    checks++; if (di.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok_gated got=%b exp=0", di.addr_ok); end
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    bit e;
    set_inst(1'b1, 1'b0, 32'h100); set_data(1'b1, 1'b0, 32'h200); mi.addr_ok = 1'b1;
    #1;
    checks++; if (di.addr_ok !== 1'b1 || ii.addr_ok !== 1'b0) begin errors++; $display("FAIL prio_first_grant got i=%b d=%b exp i=0 d=1", ii.addr_ok, di.addr_ok); end
    checks++; if (mi.addr !== 32'h200 || mi.size !== 2'd1) begin errors++; $display("FAIL prio_first_fields got addr=%h size=%0d exp addr=200 size=1", mi.addr, mi.size); end
    exp_q.push_back(1'b1);
    tick();
    set_data(1'b0, 1'b0, 32'h200);
    #1;
    checks++; if (ii.addr_ok !== 1'b1 || di.addr_ok !== 1'b0) begin errors++; $display("FAIL prio_second_grant got i=%b d=%b exp i=1 d=0", ii.addr_ok, di.addr_ok); end
    checks++; if (mi.addr !== 32'h100) begin errors++; $display("FAIL prio_second_addr got=%h exp=100", mi.addr); end
    exp_q.push_back(1'b0);
    tick();
    set_inst(1'b0, 1'b0, 32'h100); mi.addr_ok = 1'b0;
    beat(1'b1, 32'hAAAA0000);
    #1;
    e = exp_q.pop_front();
    checks++; if (di.data_ok !== e || ii.data_ok !== !e) begin errors++; $display("FAIL prio_beat1 got i=%b d=%b exp d=%b", ii.data_ok, di.data_ok, e); end
    checks++; if (di.rdata !== 32'hAAAA0000) begin errors++; $display("FAIL prio_beat1_rdata got=%h exp=aaaa0000", di.rdata); end
    tick();
    beat(1'b1, 32'h00001234);
    #1;
    e = exp_q.pop_front();
    checks++; if (di.data_ok !== e || ii.data_ok !== !e) begin errors++; $display("FAIL prio_beat2 got i=%b d=%b exp d=%b", ii.data_ok, di.data_ok, e); end
    checks++; if (ii.rdata !== 32'h00001234) begin errors++; $display("FAIL prio_beat2_rdata got=%h exp=00001234", ii.rdata); end
    tick();
    beat(1'b0, 32'h0);
  endtask

  task automatic test_lock();
    bit e;
    set_inst(1'b1, 1'b0, 32'h300); mi.addr_ok = 1'b0;
    #1;
    checks++; if (mi.req !== 1'b1 || mi.addr !== 32'h300) begin errors++; $display("FAIL lock_c0 got req=%b addr=%h exp req=1 addr=300", mi.req, mi.addr); end
    tick();
    set_data(1'b1, 1'b0, 32'h400);
    for (int c = 1; c < 3; c++) begin
      #1;
      checks++; if (mi.addr !== 32'h300 || mi.req !== 1'b1) begin errors++; $display("FAIL lock_hold_c%0d got req=%b addr=%h exp req=1 addr=300", c, mi.req, mi.addr); end
      tick();
    end
    mi.addr_ok = 1'b1;
    #1;
    checks++; if (ii.addr_ok !== 1'b1 || di.addr_ok !== 1'b0) begin errors++; $display("FAIL lock_accept got i=%b d=%b exp i=1 d=0", ii.addr_ok, di.addr_ok); end
    exp_q.push_back(1'b0);
    tick();
    set_inst(1'b0, 1'b0, 32'h300);
    #1;
    checks++; if (di.addr_ok !== 1'b1 || mi.addr !== 32'h400) begin errors++; $display("FAIL lock_next_data got d=%b addr=%h exp d=1 addr=400", di.addr_ok, mi.addr); end
    exp_q.push_back(1'b1);
    tick();
    set_data(1'b0, 1'b0, 32'h400); mi.addr_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat(1'b1, 32'h5000 + k);
      #1;
      e = exp_q.pop_front();
      checks++; if (ii.data_ok !== !e || di.data_ok !== e) begin errors++; $display("FAIL lock_drain%0d got i=%b d=%b exp d=%b", k, ii.data_ok, di.data_ok, e); end
      tick();
    end
    beat(1'b0, 32'h0);
  endtask

  task automatic test_full();
    bit e;
    set_inst(1'b1, 1'b0, 32'h600); mi.addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ii.addr = 32'h600 + 4 * k;
      #1;
      checks++; if (mi.req !== 1'b1 || ii.addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d got req=%b ok=%b exp 1 1", k, mi.req, ii.addr_ok); end
      exp_q.push_back(1'b0);
      tick();
    end
    #1;
    checks++; if (mi.req !== 1'b0 || ii.addr_ok !== 1'b0) begin errors++; $display("FAIL full_block got req=%b ok=%b exp 0 0", mi.req, ii.addr_ok); end
    beat(1'b1, 32'h7777);
    #1;
    e = exp_q.pop_front();
    checks++; if (ii.data_ok !== !e || di.data_ok !== e) begin errors++; $display("FAIL full_pop got i=%b d=%b exp d=%b", ii.data_ok, di.data_ok, e); end
    checks++; if (mi.req !== 1'b0) begin errors++; $display("FAIL full_block_on_pop got req=%b exp=0", mi.req); end
    tick();
    beat(1'b0, 32'h0);
    #1;
    checks++; if (mi.req !== 1'b1 || ii.addr_ok !== 1'b1) begin errors++; $display("FAIL full_reissue got req=%b ok=%b exp 1 1", mi.req, ii.addr_ok); end
    exp_q.push_back(1'b0);
    tick();
    set_inst(1'b0, 1'b0, 32'h0); mi.addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 32'h8000 + k);
      #1;
      e = exp_q.pop_front();
      checks++; if (ii.data_ok !== !e || di.data_ok !== e || ii.rdata !== 32'h8000 + k) begin errors++; $display("FAIL full_drain%0d got i=%b d=%b rdata=%h exp d=%b", k, ii.data_ok, di.data_ok, ii.rdata, e); end
      tick();
    end
    beat(1'b0, 32'h0);
  endtask

  task automatic test_simultaneous();
    bit e;
    set_data(1'b1, 1'b1, 32'h700); mi.addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      di.addr = 32'h700 + 4 * k;
      #1;
      checks++; if (di.addr_ok !== 1'b1 || mi.wr !== 1'b1 || mi.wstrb !== 4'h3) begin errors++; $display("FAIL simul_wr%0d got ok=%b wr=%b wstrb=%h exp 1 1 3", k, di.addr_ok, mi.wr, mi.wstrb); end
      exp_q.push_back(1'b1);
      tick();
    end
    set_data(1'b0, 1'b0, 32'h0);
    set_inst(1'b1, 1'b0, 32'h800);
    beat(1'b1, 32'h9999);
    #1;
    e = exp_q.pop_front();
    checks++; if (ii.addr_ok !== 1'b1 || di.data_ok !== e || ii.data_ok !== !e) begin errors++; $display("FAIL simul_both got iaok=%b i=%b d=%b exp iaok=1 d=%b", ii.addr_ok, ii.data_ok, di.data_ok, e); end
    exp_q.push_back(1'b0);
    tick();
    set_inst(1'b0, 1'b0, 32'h0); mi.addr_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat(1'b1, 32'hA000 + k);
      #1;
      e = exp_q.pop_front();
      checks++; if (ii.data_ok !== !e || di.data_ok !== e) begin errors++; $display("FAIL simul_drain%0d got i=%b d=%b exp d=%b", k, ii.data_ok, di.data_ok, e); end
      tick();
    end
    #1;
    checks++; if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin errors++; $display("FAIL simul_count_kept got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok); end
    tick();
    beat(1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    int issued = 0;
    int cyc = 0;
    logic ri, rd, dok, exp_req;
    logic [31:0] ai, ad, rv;
    bit e;
    mi.addr_ok = 1'b1;
    while ((issued < 10 || exp_q.size() > 0) && cyc < 200) begin
      ri  = (issued < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd  = (issued < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      dok = (exp_q.size() > 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
      ai  = 32'h1_0000 + cyc * 4;
      ad  = 32'h2_0000 + cyc * 4;
      rv  = $urandom;
      set_inst(ri, 1'b0, ai);
      set_data(rd, 1'($urandom_range(0, 1)), ad);
      beat(dok, rv);
      #1;
      exp_req = (ri || rd) && (exp_q.size() < 4);
      checks++; if (mi.req !== exp_req || di.addr_ok !== (exp_req && rd) || ii.addr_ok !== (exp_req && !rd)) begin errors++; $display("FAIL wrap_issue c%0d got req=%b i=%b d=%b exp req=%b rd=%b", cyc, mi.req, ii.addr_ok, di.addr_ok, exp_req, rd); end
      if (exp_req) begin
        checks++; if (mi.addr !== (rd ? ad : ai)) begin errors++; $display("FAIL wrap_addr c%0d got=%h exp=%h", cyc, mi.addr, rd ? ad : ai); end
      end
      if (dok) begin
        e = exp_q.pop_front();
        checks++; if (ii.data_ok !== !e || di.data_ok !== e || (e ? di.rdata : ii.rdata) !== rv) begin errors++; $display("FAIL wrap_resp c%0d got i=%b d=%b exp d=%b", cyc, ii.data_ok, di.data_ok, e); end
      end
      if (exp_req) begin
        exp_q.push_back(rd);
        issued++;
      end
      tick();
      cyc++;
    end
    checks++; if (cyc >= 200) begin errors++; $display("FAIL wrap_timeout got cycles=%0d exp <200", cyc); end
    idle_inputs();
    exp_q.delete();
  endtask

  task automatic test_empty();
    beat(1'b1, 32'hDEAD);
    #1;
    checks++; if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin errors++; $display("FAIL empty_drop got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok); end
    tick();
    beat(1'b0, 32'h0);
    set_inst(1'b1, 1'b0, 32'h900); mi.addr_ok = 1'b1;
    #1;
    checks++; if (ii.addr_ok !== 1'b1) begin errors++; $display("FAIL empty_issue got=%b exp=1", ii.addr_ok); end
    tick();
    set_inst(1'b0, 1'b0, 32'h0); mi.addr_ok = 1'b0;
    beat(1'b1, 32'hBEEF);
    #1;
    checks++; if (ii.data_ok !== 1'b1 || di.data_ok !== 1'b0) begin errors++; $display("FAIL empty_resp got i=%b d=%b exp 1 0", ii.data_ok, di.data_ok); end
    tick();
    #1;
    checks++; if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin errors++; $display("FAIL empty_count0 got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok); end
    tick();
    beat(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    set_data(1'b1, 1'b1, 32'hA00); mi.addr_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    mi.addr_ok = 1'b0;
    #1;
    checks++; if (mi.req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got req=%b exp=1", mi.req); end
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (mi.req !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%b exp=0", mi.req); end
    mi.addr_ok = 1'b1;
    #1;
    checks++; if (di.addr_ok !== 1'b0) begin errors++; $display("FAIL rstmid_addr_ok got=%b exp=0", di.addr_ok); end
    reset = 1'b0;
    set_data(1'b0, 1'b0, 32'h0);
    set_inst(1'b1, 1'b0, 32'hB00);
    #1;
    checks++; if (ii.addr_ok !== 1'b1 || mi.addr !== 32'hB00) begin errors++; $display("FAIL rstmid_idle got i=%b addr=%h exp i=1 addr=b00", ii.addr_ok, mi.addr); end
    tick();
    set_inst(1'b0, 1'b0, 32'h0); mi.addr_ok = 1'b0;
    beat(1'b1, 32'hC0DE);
    #1;
    checks++; if (ii.data_ok !== 1'b1 || di.data_ok !== 1'b0) begin errors++; $display("FAIL rstmid_resp got i=%b d=%b exp 1 0", ii.data_ok, di.data_ok); end
    tick();
    #1;
    checks++; if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin errors++; $display("FAIL rstmid_count0 got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok); end
    tick();
    beat(1'b0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_simultaneous();
    test_wrap();
    test_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
